// File: rtl/ccd_buffer_scheduler.sv
// CCD readout buffer write scheduler: prefill handshake, stream, drain, completion pulse.
// Optional watchdog on WAIT_PF/DRAIN is built in when CCD_SCHED_WATCHDOG_EN is defined.
module ccd_buffer_scheduler #(
  parameter int LEN_WIDTH      = 16,
  parameter int PREFILL_CNT    = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                 bus_clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] xfer_len,
  input  logic                 src_valid,
  output logic                 src_ready,
  output logic                 pe_en,
  input  logic                 buffer_full,
  input  logic                 pre_fill_done,
  input  logic                 buffer_drained,
  output logic                 busy,
  output logic                 done,
  output logic                 err_start_busy,
  output logic [LEN_WIDTH-1:0] words_sent,
  output logic                 timeout
);

  typedef enum logic [2:0] {IDLE, PREFILL, WAIT_PF, STREAM, DRAIN, DONE} state_t;

  localparam logic [LEN_WIDTH-1:0] PF_CNT = LEN_WIDTH'(PREFILL_CNT);

  state_t               state_q, state_d;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] pf_target;
  logic [LEN_WIDTH-1:0] ws_inc;
  logic                 start_ok;
  logic                 wd_hit;

  assign pf_target = (len_q < PF_CNT) ? len_q : PF_CNT;
  assign ws_inc    = words_sent + LEN_WIDTH'(1);
  assign start_ok  = start && (state_q == IDLE);

  // Leaving PREFILL/STREAM on the final write keeps words_sent within target and len.
  assign src_ready = ((state_q == PREFILL) || (state_q == STREAM)) && !buffer_full &&
                     (words_sent < len_q);
  assign pe_en     = src_valid && src_ready;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (xfer_len == '0) ? DONE : PREFILL;
      PREFILL: if (pe_en && (ws_inc == pf_target)) state_d = WAIT_PF;
      WAIT_PF: begin
        if (wd_hit)             state_d = DONE;
        else if (pre_fill_done) state_d = (words_sent == len_q) ? DRAIN : STREAM;
      end
      STREAM:  if (pe_en && (ws_inc == len_q)) state_d = DRAIN;
      DRAIN:   if (wd_hit || buffer_drained) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      words_sent     <= '0;
      err_start_busy <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        words_sent     <= '0;
        err_start_busy <= 1'b0;
      end else begin
        if (pe_en) words_sent <= ws_inc;
        if (start) err_start_busy <= 1'b1;
      end
    end
  end

  // Transfer length is datapath; its use is gated by state, so it needs no reset.
  always_ff @(posedge bus_clk) begin
    if (start_ok) len_q <= xfer_len;
  end

`ifdef CCD_SCHED_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            waiting;
  logic            timeout_q;

  assign waiting = (state_q == WAIT_PF) || (state_q == DRAIN);
  // Fires on the cycle whose increment would reach the limit, so DONE lands exactly
  // TIMEOUT_CYCLES cycles after entering a waiting state.
  assign wd_hit  = waiting && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign timeout = timeout_q;

  always_ff @(posedge bus_clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_d != state_q) wd_cnt <= '0;
      else if (waiting)       wd_cnt <= wd_cnt + WD_W'(1);
      if (start_ok)    timeout_q <= 1'b0;
      else if (wd_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign wd_hit  = 1'b0;
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule
